// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, the per-operation flag type,
// binary32 field widths, canonical quiet NaN and skid-buffer state encodings.
package fpu_pkg;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef logic [3:0] fpu_flags_t;

  localparam int FP32_WIDTH = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/fpu_skid_buffer.sv
// Two-entry FIFO skid buffer. in_ready is a flop, so downstream backpressure
// never reaches the upstream ready combinationally.
module fpu_skid_buffer
  import fpu_pkg::*;
#(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   state
);

  // Handshake: a beat moves on a rising edge where valid & ready are both high;
  // valid never depends on ready, and data is held while valid & !ready.
  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, drain;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign state     = state_q;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// FPU adder output stage: IEEE special-value substitution, skid-buffered
// output, sticky accrued flags and a saturating invalid-operation counter.
module fpu_result_stage
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP32_WIDTH,
  parameter int EXP_W = FP32_EXP_W,
  parameter int MAN_W = FP32_MAN_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_overflow,
  input  logic             in_invalid,
  input  logic             in_underflow,
  input  logic             in_inexact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             flags_clr,
  output logic [3:0]       accrued_flags,
  output logic [CNT_W-1:0] inv_count,
  output logic [1:0]       dbg_state
);

  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [WIDTH-1:0] sub_result;
  fpu_flags_t       sub_flags;
  fpu_flags_t       accrued_q, accrued_d;
  logic [CNT_W-1:0] inv_count_q, inv_count_d;
  logic             accept;

  always_comb begin
    sub_result = in_result;
    sub_flags  = '0;
    sub_flags[FLAG_UF] = in_underflow;
    sub_flags[FLAG_NX] = in_inexact;
    if (in_invalid) begin
      sub_result = QNAN;
      sub_flags  = '0;
      sub_flags[FLAG_NV] = 1'b1;
    end else if (in_overflow) begin
      sub_result = {in_result[WIDTH-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sub_flags[FLAG_OF] = 1'b1;
      sub_flags[FLAG_NX] = 1'b1;
    end
  end

  fpu_skid_buffer #(.W(WIDTH + 4)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sub_result, sub_flags}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_result, out_flags}),
    .state     (dbg_state)
  );

  assign accept = in_valid & in_ready;

  // A clear in the same cycle as an accept keeps only the new op's flags.
  always_comb begin
    accrued_d   = (flags_clr ? 4'b0000 : accrued_q) | (accept ? sub_flags : 4'b0000);
    inv_count_d = inv_count_q;
    if (accept && sub_flags[FLAG_NV] && (inv_count_q != {CNT_W{1'b1}}))
      inv_count_d = inv_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accrued_q   <= '0;
      inv_count_q <= '0;
    end else begin
      accrued_q   <= accrued_d;
      inv_count_q <= inv_count_d;
    end
  end

  assign accrued_flags = accrued_q;
  assign inv_count     = inv_count_q;

endmodule

// File: tb/tb_fpu_result_stage.sv
// Directed bench for fpu_result_stage: driver pushes hand-computed expected
// {result, flags} into a queue, a negedge monitor pops and compares on drain.
module tb_fpu_result_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = '0;
  logic             in_overflow = 1'b0;
  logic             in_invalid = 1'b0;
  logic             in_underflow = 1'b0;
  logic             in_inexact = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic             flags_clr = 1'b0;
  logic [3:0]       accrued_flags;
  logic [CNT_W-1:0] inv_count;
  logic [1:0]       dbg_state;

  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpu_result_stage #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_overflow   (in_overflow),
    .in_invalid    (in_invalid),
    .in_underflow  (in_underflow),
    .in_inexact    (in_inexact),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .flags_clr     (flags_clr),
    .accrued_flags (accrued_flags),
    .inv_count     (inv_count),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // fl = {invalid, overflow, underflow, inexact}; called at posedge+#1.
  task automatic send(input logic [31:0] r, input logic [3:0] fl, input logic clr,
                      input logic [31:0] exp_r, input logic [3:0] exp_f);
    bit ok = 1'b0;
    in_valid     = 1'b1;
    in_result    = r;
    in_invalid   = fl[3];
    in_overflow  = fl[2];
    in_underflow = fl[1];
    in_inexact   = fl[0];
    flags_clr    = clr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    else exp_q.push_back({exp_r, exp_f});
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flags_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {28'd0, out_result, out_flags}, 64'd0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("out_result", {32'd0, out_result}, {32'd0, e[35:4]});
        check("out_flags", {60'd0, out_flags}, {60'd0, e[3:0]});
      end
    end
  end

  initial begin
    // Reset values
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_flags", {60'd0, out_flags}, 64'd0);
    check("rst_accrued", {60'd0, accrued_flags}, 64'd0);
    check("rst_inv_count", {60'd0, inv_count}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Overflow: negative sign kept, OF+NX
    send(32'hC123_4567, 4'b0100, 1'b0, 32'hFF80_0000, 4'b0101);
    check("ovf_accrued", {60'd0, accrued_flags}, 64'h5);
    check("ovf_out_valid", {63'd0, out_valid}, 64'd1);

    // Invalid wins over overflow
    send(32'h3F80_0000, 4'b1100, 1'b0, 32'h7FC0_0000, 4'b1000);
    check("inv_count_1", {60'd0, inv_count}, 64'd1);
    check("inv_accrued", {60'd0, accrued_flags}, 64'hD);

    // Passthrough and overflow with underflow input, back to back
    send(32'h1234_5678, 4'b0011, 1'b0, 32'h1234_5678, 4'b0011);
    send(32'h4100_0000, 4'b0110, 1'b0, 32'h7F80_0000, 4'b0111);
    send(32'h8000_0001, 4'b0000, 1'b0, 32'h8000_0001, 4'b0000);
    check("pass_accrued", {60'd0, accrued_flags}, 64'hF);

    // Clear alone, then clear colliding with an accepted invalid op
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check("clr_accrued", {60'd0, accrued_flags}, 64'h0);
    check("clr_keeps_count", {60'd0, inv_count}, 64'd1);
    send(32'h0000_0001, 4'b0011, 1'b0, 32'h0000_0001, 4'b0011);
    check("pre_collide_accrued", {60'd0, accrued_flags}, 64'h3);
    send(32'h0000_0000, 4'b1000, 1'b1, 32'h7FC0_0000, 4'b1000);
    check("collide_accrued", {60'd0, accrued_flags}, 64'h8);
    check("inv_count_2", {60'd0, inv_count}, 64'd2);
    @(posedge clk); #1;

    // Backpressure: A, B accepted, C waits until drain
    out_ready = 1'b0;
    send(32'hAAAA_0001, 4'b0000, 1'b0, 32'hAAAA_0001, 4'b0000);
    send(32'hBBBB_0002, 4'b0001, 1'b0, 32'hBBBB_0002, 4'b0001);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_state_full", {62'd0, dbg_state}, 64'd2);
    check("bp_main_holds_a", {32'd0, out_result}, 64'hAAAA_0001);
    fork
      send(32'hCCCC_0003, 4'b0010, 1'b0, 32'hCCCC_0003, 4'b0010);
      begin
        repeat (3) @(posedge clk);
        check("bp_hold_a", {32'd0, out_result}, 64'hAAAA_0001);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Counter saturation at CNT_W=4
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    for (int i = 1; i <= 17; i++) begin
      send(32'h0000_0000, 4'b1000, 1'b0, 32'h7FC0_0000, 4'b1000);
      if (i == 14) check("inv_count_14", {60'd0, inv_count}, 64'd14);
      if (i == 15) check("inv_count_15", {60'd0, inv_count}, 64'd15);
    end
    check("inv_count_sat", {60'd0, inv_count}, 64'd15);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream while FULL
    out_ready = 1'b0;
    send(32'h1111_1111, 4'b0001, 1'b0, 32'h1111_1111, 4'b0001);
    send(32'h2222_2222, 4'b1000, 1'b0, 32'h7FC0_0000, 4'b1000);
    check("pre_rst_state", {62'd0, dbg_state}, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_result", {32'd0, out_result}, 64'd0);
    check("mid_rst_out_flags", {60'd0, out_flags}, 64'd0);
    check("mid_rst_accrued", {60'd0, accrued_flags}, 64'd0);
    check("mid_rst_inv_count", {60'd0, inv_count}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h3333_3333, 4'b0000, 1'b0, 32'h3333_3333, 4'b0000);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_result_stage.md
# fpu_result_stage

Registered output stage of the FPU adder path, directly downstream of the adder's exception logic. Each cycle it accepts one packed result plus its exception flags and substitutes IEEE-754 special values for invalid and overflow cases. It holds results in a two-entry skid buffer behind a valid/ready handshake and maintains the sticky accrued-flag register and a saturating invalid-operation counter read by the control/status path.

## Interface
- WIDTH, 32, packed result width (sign + EXP_W + MAN_W)
- EXP_W, 8, exponent field width
- MAN_W, 23, mantissa field width
- CNT_W, 16, invalid-event counter width
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream result and flags are valid
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- in_result  in  WIDTH  unrounded-exception packed result {sign, exp, man}
- in_overflow  in  1  overflow flag from adder exception logic
- in_invalid  in  1  invalid flag from adder exception logic
- in_underflow  in  1  underflow flag
- in_inexact  in  1  inexact flag
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts; transfer when out_valid & out_ready
- out_result  out  WIDTH  final result after substitution
- out_flags  out  4  per-operation flags {NV, OF, UF, NX} (bits 3..0)
- flags_clr  in  1  one-cycle pulse, clears accrued flags
- accrued_flags  out  4  sticky OR of accepted per-op flags, same bit order
- inv_count  out  CNT_W  saturating count of accepted invalid operations

## Operation
- Substitution, computed combinationally at the input, stored already substituted:
  - in_invalid=1: result = canonical qNaN {0, all-ones exp, 1, zeros}, i.e. 0x7FC00000 at defaults. Flags NV=1, OF=0, UF=0, NX=0. Invalid has priority over overflow.
  - else in_overflow=1: result = {in_result sign, all-ones exp, zero man}. Flags OF=1, NX=1, UF from input.
  - else: result passes unchanged. Flags pass unchanged.
- Skid buffer, two entries (main, skid):
  - States: EMPTY (main empty), ONE (main full, skid empty), FULL (both full).
  - in_ready = (state != FULL), registered. No combinational path from out_ready to in_ready.
  - EMPTY + accept → ONE.
  - ONE + accept + no drain → FULL, new entry goes to skid.
  - ONE + drain + no accept → EMPTY.
  - ONE + accept + drain → ONE, main replaced.
  - FULL + drain → ONE, skid moves to main.
  - out_valid = (state != EMPTY). out_result/out_flags always come from main. Order is strictly FIFO.
- Accrued flags update on input acceptance, not on output drain:
  - accrued <= (flags_clr ? 0 : accrued) | (accept ? substituted flags : 0).
  - Simultaneous clear and accept leaves only the new operation's flags.
- inv_count increments by 1 on each accepted operation with NV=1 and saturates at all-ones. flags_clr does not clear it; only rst does.

## Timing
- Reset values: out_valid=0, in_ready=1, out_result=0, out_flags=0, accrued_flags=0, inv_count=0, state=EMPTY.
- Latency: an input accepted at edge N is visible on out_result at N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous drain.
- Throughput: one result per cycle while out_ready=1.
- Once out_valid is high, out_result and out_flags hold stable until drained.
- Accrued-flag and counter updates are visible the cycle after acceptance.
- rst asserted mid-operation discards both entries immediately (asynchronously). No partial transfer completes on that edge.

## Structure
- Shared package fpu_pkg holds:
  - flag bit indices (FLAG_NV=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0)
  - a 4-bit fpu_flags_t typedef
  - field widths
  - the QNAN_32 constant
- One sub-module, fpu_skid_buffer, parameterised on payload width (WIDTH+4). It holds the state machine and the two data registers.
- Substitution logic, accrued flags and the counter live in fpu_result_stage.

## Test plan
- Overflow: in_result=0xC1234567, in_overflow=1, out_ready=1 → next cycle out_result=0xFF800000, out_flags=4'b0101, accrued_flags=4'b0101.
- Invalid over overflow: in_invalid=1, in_overflow=1, in_result=0x3F800000 → out_result=0x7FC00000, out_flags=4'b1000, inv_count=1.
- Backpressure: out_ready=0 while 3 valid inputs A, B, C are offered → A and B accepted, in_ready=0 from the cycle after B. Raising out_ready yields A, B, C in order with no loss or duplication.
- Clear collision: accrued=4'b0011, flags_clr=1 in the same cycle as an accepted invalid op → accrued_flags=4'b1000.
- Counter saturation: CNT_W=4, 17 accepted invalid ops → inv_count=15.
- Reset mid-stream: rst asserted while FULL → out_valid=0, in_ready=1 and all outputs at reset values without waiting for a clock edge.
